exp_bit_scanner: RTL
====================

# exp_bit_scanner

Sequencer for the exponent ROM (`e_mem`, single-port M4K, registered address and registered output) in the ModExp datapath. On `start` it reads the exponent words from the ROM, most significant word first, and serializes them MSB-first into a valid/ready bit stream. The square-and-multiply controller consumes that stream. It hides the ROM's 2-cycle read latency with a one-word prefetch buffer, so bits stream without bubbles. It can optionally discard leading zero bits.

## Interface
Parameters:
- `ADDR_WIDTH`, 7, ROM address width
- `DATA_WIDTH`, 32, ROM word width; must be ≥ 3
- `TOTAL_ADDR`, 128, number of exponent words; the exponent is `TOTAL_ADDR*DATA_WIDTH` bits

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `skip_lz`  in  1  discard leading zero bits; sampled with `start`
- `abort`  in  1  synchronous cancel; returns to IDLE next cycle with no `done`
- `mem_addr`  out  `ADDR_WIDTH`  ROM address (registered)
- `mem_q`  in  `DATA_WIDTH`  ROM data; valid 2 cycles after the matching `mem_addr`
- `bit_valid`  out  1  `bit_out` is valid
- `bit_ready`  in  1  consumer accepts the bit
- `bit_out`  out  1  current exponent bit
- `bit_first`  out  1  qualifies the first emitted bit
- `bit_last`  out  1  qualifies bit 0 of word 0
- `busy`  out  1  high from the cycle after `start` until `done`/abort
- `done`  out  1  one-cycle pulse after the last bit is accepted, or after an all-zero scan
- `zero_exp`  out  1  held with and after `done` when `skip_lz` found no 1 bit; cleared on next `start`

## Operation
- Word order: address `TOTAL_ADDR-1` is most significant. Words are read descending to 0. Bits within a word go from `DATA_WIDTH-1` down to 0.
- FSM states:
  - IDLE → FILL on `start`.
  - FILL: issue the first address and wait out the latency; load the shifter → STREAM.
  - STREAM: shift on each handshake; prefetch the next word into the buffer → DRAIN after the last bit handshake.
  - DRAIN: pulse `done` → IDLE.
- Prefetch: the next address is issued the cycle after a word loads into the shifter. The buffer captures `mem_q` on its valid cycle. The shifter reloads from the buffer on the handshake of the word's bit 0, so there is no gap. Internal counters track the word index (`ADDR_WIDTH` bits) and the bit index (`clog2(DATA_WIDTH)` bits). No counter wraps: the scan ends at word 0, bit 0.
- Handshake:
  - A bit transfers when `bit_valid && bit_ready`.
  - `bit_out`, `bit_first` and `bit_last` hold stable while `bit_valid && !bit_ready`.
  - `bit_valid` never drops without a transfer, except on abort or reset.
- skip_lz=1: zero bits before the first 1 are consumed internally at one per cycle, with `bit_valid` low. The first emitted bit is therefore 1, with `bit_first=1`. If all bits are zero: no bits are emitted, `zero_exp=1`, and `done` pulses.
- skip_lz=0: exactly `TOTAL_ADDR*DATA_WIDTH` bits are emitted.
- `start` while busy is ignored. If `abort` and `start` are asserted together in IDLE, `abort` wins.
- Abort or reset mid-scan discards all buffered data. An in-flight ROM read is ignored.

## Timing
- Reset values: `mem_addr=0`, `bit_valid=0`, `bit_out=0`, `bit_first=0`, `bit_last=0`, `busy=0`, `done=0`, `zero_exp=0`; FSM in IDLE.
- `start` is high in cycle 0. Then:
  - `busy` and `mem_addr=TOTAL_ADDR-1` in cycle 1.
  - `mem_q` valid in cycle 3.
  - First `bit_valid` in cycle 4 (skip_lz=0).
- With `bit_ready` held high, bits transfer every cycle with no bubbles at word boundaries.
- Leading-zero skipping costs 1 cycle per skipped bit. Word fetches overlap the skipping.
- `done` pulses in the cycle after the `bit_last` handshake. `busy` falls in that same cycle.
- After `abort`: `bit_valid=0` and `busy=0` in the next cycle, and `done` is not pulsed.

## Test plan
Overrides for all scenarios: `TOTAL_ADDR=4`, `DATA_WIDTH=8`, `ADDR_WIDTH=2`. ROM model has 2-cycle latency.
- ROM {3:0x00, 2:0x05, 1:0x00, 0:0x81}, skip_lz=0, ready=1 → 32 bits in cycles 4–35, equal to 0x00050081 MSB-first; `bit_first` on bit 1, `bit_last` on bit 32; `done` in cycle 36.
- Same ROM, skip_lz=1 → 19 bits, equal to 101_0000_0000_1000_0001; first bit is 1 with `bit_first`; `zero_exp=0`.
- Same ROM, skip_lz=0, `bit_ready` randomized at 30% duty → identical 32-bit sequence; outputs stable while stalled; exactly one `done`.
- ROM all 0x00, skip_lz=1 → `bit_valid` never high; `done` pulse with `zero_exp=1`; `zero_exp` clears on the next `start`.
- `start` pulsed mid-stream → ignored, stream unchanged. `abort` at bit 10 → `bit_valid=0` and `busy=0` next cycle, no `done`; a new scan then restarts at address 3.
- `resetn` low mid-stream (asynchronously, between edges) → all outputs take their reset values immediately; a scan after reset release produces the full correct stream.

Source files
------------

// File: rtl/exp_bit_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : exp_bit_scanner_if
// Brief    : Exponent ROM port and serial bit-stream handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface exp_bit_scanner_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  bit_valid;
    logic                  bit_ready;
    logic                  bit_out;
    logic                  bit_first;
    logic                  bit_last;

    modport master (
        output mem_addr,
        input  mem_q,
        output bit_valid,
        input  bit_ready,
        output bit_out,
        output bit_first,
        output bit_last
    );

    modport slave (
        input  mem_addr,
        output mem_q,
        input  bit_valid,
        output bit_ready,
        input  bit_out,
        input  bit_first,
        input  bit_last
    );
endinterface
`default_nettype wire

// File: rtl/exp_bit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : exp_bit_scanner
// Brief    : Reads exponent words MSW-first from a 2-cycle ROM and serializes
//            them MSB-first onto a valid/ready bit stream, optionally
//            discarding leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module exp_bit_scanner #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int TOTAL_ADDR = 128
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              skip_lz,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              zero_exp,
    exp_bit_scanner_if.master bus
);

    localparam int                    c_BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_TOP_WORD = ADDR_WIDTH'(TOTAL_ADDR - 1);
    localparam logic [c_BIT_W-1:0]    c_TOP_BIT  = c_BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_issue;
    logic [1:0]            r_q_pipe;
    logic                  r_skipping;
    logic                  r_first;
    logic                  r_zero_exp;

    logic                  w_stream;
    logic                  w_cur;
    logic                  w_emit;
    logic                  w_skip;
    logic                  w_consume;
    logic                  w_final;
    logic                  w_word_end;

    assign w_stream   = (r_state == S_STREAM);
    assign w_cur      = r_shift[DATA_WIDTH-1];
    // While skipping, a 1 at the shifter head stops the skip and becomes the first emitted bit
    assign w_emit     = w_stream && (!r_skipping || w_cur);
    assign w_skip     = w_stream && r_skipping && !w_cur;
    assign w_consume  = (w_emit && bus.bit_ready) || w_skip;
    assign w_word_end = (r_bit == '0);
    assign w_final    = w_word_end && (r_word == '0);

    assign bus.mem_addr  = r_mem_addr;
    assign bus.bit_valid = w_emit;
    assign bus.bit_out   = w_stream && w_cur;
    assign bus.bit_first = w_emit && r_first;
    assign bus.bit_last  = w_emit && w_final;
    assign zero_exp      = r_zero_exp;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                if (r_q_pipe[1]) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if (w_consume && w_final) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
        end
    end

    // r_issue marks the cycle a fresh address sits on mem_addr; r_q_pipe[1] is its data-valid cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mem_addr <= '0;
            r_word     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_issue    <= 1'b0;
            r_q_pipe   <= '0;
            r_skipping <= 1'b0;
            r_first    <= 1'b0;
            r_zero_exp <= 1'b0;
        end else begin
            r_issue  <= 1'b0;
            r_q_pipe <= {r_q_pipe[0], r_issue};
            if (abort) begin
                r_q_pipe <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mem_addr <= c_TOP_WORD;
                            r_issue    <= 1'b1;
                            r_word     <= c_TOP_WORD;
                            r_skipping <= skip_lz;
                            r_first    <= 1'b1;
                            r_zero_exp <= 1'b0;
                        end
                    end
                    S_FILL: begin
                        if (r_q_pipe[1]) begin
                            r_shift <= bus.mem_q;
                            r_bit   <= c_TOP_BIT;
                            if (r_word != '0) begin
                                r_mem_addr <= r_word - 1'b1;
                                r_issue    <= 1'b1;
                            end
                        end
                    end
                    S_STREAM: begin
                        if (r_q_pipe[1]) begin
                            r_buf <= bus.mem_q;
                        end
                        if (w_consume) begin
                            if (w_emit) begin
                                r_first    <= 1'b0;
                                r_skipping <= 1'b0;
                            end
                            if (w_final) begin
                                r_zero_exp <= w_skip;
                            end else if (w_word_end) begin
                                // Prefetched word may arrive in this very cycle, so bypass the buffer
                                r_shift <= r_q_pipe[1] ? bus.mem_q : r_buf;
                                r_bit   <= c_TOP_BIT;
                                r_word  <= r_word - 1'b1;
                                if (r_word != ADDR_WIDTH'(1)) begin
                                    r_mem_addr <= r_word - ADDR_WIDTH'(2);
                                    r_issue    <= 1'b1;
                                end
                            end else begin
                                r_shift <= r_shift << 1;
                                r_bit   <= r_bit - 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
